pipeline_register: RTL and testbench

Parameterized, write-enabled storage register with synchronous reset. It is the basic state element of the pipeline latches, such as the IF/ID latch that holds the fetched instruction and next-PC. It also serves as the generic register used across the datapath. Each instance captures its data input on the rising clock edge when enabled, and otherwise holds its value.

---
 rtl/pipeline_register_pkg.sv | 7 +
 rtl/pipeline_register_dff.sv | 31 +++
 rtl/pipeline_register.sv | 44 ++++
 tb/tb_pipeline_register.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipeline_register_pkg.sv
// Project-wide constants shared by the datapath storage elements.
package pipeline_register_pkg;

    // Machine word size. Used as the default register width.
    localparam int unsigned WORD_WIDTH = 16;

endpackage : pipeline_register_pkg

// File: rtl/pipeline_register_dff.sv
// Single-bit flip-flop with synchronous active-high reset.
// The value loaded on reset is a per-instance constant bit.
module pipeline_register_dff #(
    parameter bit RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next value of the bit is simply the data presented to the flop.
    always_comb begin
        q_d = d;
    end

    // Capture on the rising edge; reset takes priority over the data input.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : pipeline_register_dff

// File: rtl/pipeline_register.sv
// Write-enabled storage register with synchronous reset.
// Used for the pipeline latches (e.g. IF/ID) and as the generic datapath
// register. The read port is driven straight from the flops, so there is
// no combinational path from w or we to r.
module pipeline_register
    import pipeline_register_pkg::*;
#(
    parameter int unsigned       WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;

    // Hold mux in front of every bit: take new data when enabled, otherwise
    // feed the stored value back so the register keeps its contents.
    always_comb begin
        r_d = r_q;
        if (we) begin
            r_d = w;
        end
    end

    // One flop per stored bit, each with its own bit of the reset value.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        pipeline_register_dff #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_dff (
            .clk (clk),
            .rst (rst),
            .d   (r_d[i]),
            .q   (r_q[i])
        );
    end

    assign r = r_q;

endmodule : pipeline_register

// File: tb/tb_pipeline_register.sv
// Self-checking bench for pipeline_register. Two instances are exercised in
// lockstep: the default 16-bit register with zero reset value, and an 8-bit
// register with reset value 0xA5. A driver issues stimulus on the falling
// edge and pushes the expected post-edge contents into a scoreboard queue;
// a monitor pops and compares just after each rising edge.
module tb_pipeline_register;

    localparam logic [15:0] RESET16 = 16'h0000;
    localparam logic [7:0]  RESET8  = 8'hA5;

    typedef struct {
        logic [15:0] exp16;
        logic [7:0]  exp8;
        string       tag;
    } sb_entry_t;

    logic        clk;
    logic        rst;
    logic        we;
    logic [15:0] w16;
    logic [7:0]  w8;
    logic [15:0] r16;
    logic [7:0]  r8;

    sb_entry_t   sb_q[$];
    int          checks_total;
    int          checks_passed;

    // Reference model state: the value each register should hold.
    logic [15:0] model16;
    logic [7:0]  model8;

    pipeline_register u_dut16 (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .w   (w16),
        .r   (r16)
    );

    pipeline_register #(
        .WIDTH       (8),
        .RESET_VALUE (RESET8)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .w   (w8),
        .r   (r8)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and count it.
    task automatic check_output(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, advance the model by the
    // reset/write/hold rules and queue the value expected after the next edge.
    task automatic apply_stimulus(input logic rst_i, input logic we_i,
                                  input logic [15:0] w16_i,
                                  input logic [7:0] w8_i, input string tag);
        sb_entry_t e;
        @(negedge clk);
        rst = rst_i;
        we  = we_i;
        w16 = w16_i;
        w8  = w8_i;
        if (rst_i) begin
            model16 = RESET16;
            model8  = RESET8;
        end else if (we_i) begin
            model16 = w16_i;
            model8  = w8_i;
        end
        e.exp16 = model16;
        e.exp8  = model8;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: just after each rising edge, pop the pending expectation.
    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_output({e.tag, "_r16"}, r16, e.exp16);
            check_output({e.tag, "_r8"}, {8'h00, r8}, {8'h00, e.exp8});
        end
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b0;
        we  = 1'b0;
        w16 = '0;
        w8  = '0;
        model16 = 'x;
        model8  = 'x;

        // Reset wins over a simultaneous write.
        apply_stimulus(1'b1, 1'b1, 16'hBEEF, 8'h11, "reset");

        // Back-to-back writes, one cycle latency each.
        apply_stimulus(1'b0, 1'b1, 16'h1234, 8'h3C, "write_a");
        apply_stimulus(1'b0, 1'b1, 16'hABCD, 8'hFF, "write_b");

        // Load then hold for 5 cycles while w toggles.
        apply_stimulus(1'b0, 1'b1, 16'h5A5A, 8'h5A, "load_hold");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b0, (i % 2 == 0) ? 16'hFFFF : 16'h0000,
                           (i % 2 == 0) ? 8'hFF : 8'h00, "hold");
        end

        // Mid-operation reset with write asserted, then normal write.
        apply_stimulus(1'b0, 1'b1, 16'h0800, 8'h08, "load_0800");
        apply_stimulus(1'b1, 1'b1, 16'h7777, 8'h77, "rst_prio");
        apply_stimulus(1'b0, 1'b1, 16'h7777, 8'h77, "post_rst_write");

        // Randomized traffic: ~5% reset, random enable and data.
        for (int i = 0; i < 1000; i++) begin
            apply_stimulus(($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                           1'($urandom_range(0, 1)),
                           16'($urandom), 8'($urandom), "random");
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() > 0) begin
            checks_total++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0",
                     sb_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_pipeline_register
